// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-port ROM burst arbiter.
// Optional feature macro: ROM_ARB_RR_EN (round-robin arbitration, see rom_arb_pick).
package rom_arbiter_pkg;

    // FSM encoding: IDLE arbitrates, BURST streams words.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Port identifiers used for owner / last_owner / winner.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage : rom_arbiter_pkg

// File: rtl/rom_arb_pick.sv
// Combinational winner select between the two requesters.
// ROM_ARB_RR_EN defined: round-robin on a contest (the port that did not own the last burst wins).
// ROM_ARB_RR_EN undefined: fixed priority, port 0 always wins; last_owner is ignored.
module rom_arb_pick
    import rom_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic winner
);

`ifdef ROM_ARB_RR_EN
    // Lone requester wins outright; on a contest the previous owner yields.
    always_comb begin
        winner = PORT0;
        if (req0 && req1) begin
            winner = (last_owner == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            winner = PORT1;
        end
    end
`else
    // Fixed priority has no use for history; tie it off explicitly.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Port 0 wins whenever it asks; port 1 only when port 0 is quiet.
    always_comb begin
        winner = PORT0;
        if (!req0 && req1) begin
            winner = PORT1;
        end
    end
`endif

endmodule : rom_arb_pick

// File: rtl/rom_arbiter.sv
// Two-port burst arbiter in front of a combinational ROM.
// Sequences incrementing ROM addresses for the granted port and returns one
// registered word per cycle with a per-port valid strobe and last flag.
// Optional feature macro: ROM_ARB_RR_EN (selected inside rom_arb_pick).
//
// Handshake: a requester raises reqN with addrN/lenN and holds all three stable
// until it sees the one-cycle gntN pulse. A request is accepted only in IDLE.
// After gntN the burst streams len+1 words, each marked by vldN, the final one
// also by lastN. A req still high in the IDLE cycle after a burst is a new request.
// There is no back-pressure on the return path: vldN words must be taken as they come.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [LWIDTH-1:0] len0,
    output logic              gnt0,
    output logic              vld0,
    output logic              last0,
    input  logic              req1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [LWIDTH-1:0] len1,
    output logic              gnt1,
    output logic              vld1,
    output logic              last1,
    output logic [DWIDTH-1:0] rdata,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    output logic              fsm_state
);

    state_t            state, state_d;
    logic              owner, owner_d;
    logic              last_owner, last_owner_d;
    logic [LWIDTH-1:0] cnt, cnt_d;
    logic [AWIDTH-1:0] rom_addr_d;
    logic [DWIDTH-1:0] rdata_d;
    logic              gnt0_d, gnt1_d, vld0_d, vld1_d, last0_d, last1_d;
    logic              winner;

    rom_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner),
        .winner     (winner)
    );

    assign fsm_state = state;

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        cnt_d        = cnt;
        rom_addr_d   = rom_addr;
        rdata_d      = rdata;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        vld0_d       = 1'b0;
        vld1_d       = 1'b0;
        last0_d      = 1'b0;
        last1_d      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d    = winner;
                    rom_addr_d = (winner == PORT1) ? addr1 : addr0;
                    cnt_d      = (winner == PORT1) ? len1 : len0;
                    gnt0_d     = (winner == PORT0);
                    gnt1_d     = (winner == PORT1);
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                rdata_d    = rom_data;
                vld0_d     = (owner == PORT0);
                vld1_d     = (owner == PORT1);
                rom_addr_d = rom_addr + AWIDTH'(1);
                cnt_d      = cnt - LWIDTH'(1);
                if (cnt == '0) begin
                    last0_d      = (owner == PORT0);
                    last1_d      = (owner == PORT1);
                    last_owner_d = owner;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= PORT0;
            last_owner <= PORT1;
            cnt        <= '0;
            rom_addr   <= '0;
            rdata      <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            vld0       <= 1'b0;
            vld1       <= 1'b0;
            last0      <= 1'b0;
            last1      <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            cnt        <= cnt_d;
            rom_addr   <= rom_addr_d;
            rdata      <= rdata_d;
            gnt0       <= gnt0_d;
            gnt1       <= gnt1_d;
            vld0       <= vld0_d;
            vld1       <= vld1_d;
            last0      <= last0_d;
            last1      <= last1_d;
        end
    end

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural combinational ROM model.
// Expectations are hand-derived; the round-robin case follows ROM_ARB_RR_EN.
module tb_rom_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1;
    logic [7:0]  addr0, addr1;
    logic [3:0]  len0, len1;
    logic        gnt0, vld0, last0, gnt1, vld1, last1;
    logic [15:0] rdata;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        fsm_state;

    int checks   = 0;
    int failures = 0;

`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    rom_arbiter #(.DWIDTH(16), .AWIDTH(8), .LWIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .addr0     (addr0),
        .len0      (len0),
        .gnt0      (gnt0),
        .vld0      (vld0),
        .last0     (last0),
        .req1      (req1),
        .addr1     (addr1),
        .len1      (len1),
        .gnt1      (gnt1),
        .vld1      (vld1),
        .last1     (last1),
        .rdata     (rdata),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fsm_state (fsm_state)
    );

    // ROM contents: distinct per address, easy to recompute by hand.
    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of the strobes: {gnt0,gnt1,vld0,vld1,last0,last1}.
    function automatic logic [31:0] flags();
        return {26'd0, gnt0, gnt1, vld0, vld1, last0, last1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] a;
        logic       p;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        reset_n = 1'b1;
        #2;
        do_reset();

        // Reset state.
        chk("rst_flags", flags(), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_state", 32'(fsm_state), 32'h0);

        // 1: port 0 burst of 4 words from 0x10.
        req0 = 1'b1; addr0 = 8'h10; len0 = 4'd3;
        step();
        chk("t1_gnt", flags(), 32'b100000);
        chk("t1_rom_addr", 32'(rom_addr), 32'h10);
        req0 = 1'b0;
        a = 8'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_flags", flags(), (i == 3) ? 32'b001010 : 32'b001000);
            chk("t1_rdata", 32'(rdata), 32'(rom_word(a)));
            a = a + 8'd1;
        end
        step();
        chk("t1_idle", flags(), 32'h0);

        // 2: both ports held with len=0; fresh reset so the first contest is fresh.
        do_reset();
        req0 = 1'b1; addr0 = 8'h20; len0 = 4'd0;
        req1 = 1'b1; addr1 = 8'h30; len1 = 4'd0;
        for (int k = 0; k < 4; k++) begin
            p = RR ? k[0] : 1'b0;
            step();
            chk("t2_gnt", flags(), p ? 32'b010000 : 32'b100000);
            step();
            chk("t2_vld", flags(), p ? 32'b000101 : 32'b001010);
            chk("t2_rdata", 32'(rdata), 32'(rom_word(p ? 8'h30 : 8'h20)));
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("t2_idle", flags(), 32'h0);

        // 3: port 1 burst crossing the top of the address space.
        req1 = 1'b1; addr1 = 8'hFE; len1 = 4'd3;
        step();
        chk("t3_gnt", flags(), 32'b010000);
        chk("t3_rom_addr", 32'(rom_addr), 32'hFE);
        req1 = 1'b0;
        a = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_flags", flags(), (i == 3) ? 32'b000101 : 32'b000100);
            chk("t3_rdata", 32'(rdata), 32'(rom_word(a)));
            a = a + 8'd1;
            chk("t3_rom_addr_wrap", 32'(rom_addr), 32'(a));
        end
        step();
        chk("t3_idle", flags(), 32'h0);

        // 4: port 1 asks during a port 0 burst and must wait for it to finish.
        req0 = 1'b1; addr0 = 8'h40; len0 = 4'd3;
        step();
        chk("t4_gnt0", flags(), 32'b100000);
        req0 = 1'b0;
        a = 8'h40;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin
                req1 = 1'b1; addr1 = 8'h50; len1 = 4'd1;
            end
            chk("t4_p0_flags", flags(), (i == 3) ? 32'b001010 : 32'b001000);
            chk("t4_p0_rdata", 32'(rdata), 32'(rom_word(a)));
            a = a + 8'd1;
        end
        step();
        chk("t4_gnt1", flags(), 32'b010000);
        req1 = 1'b0;
        step();
        chk("t4_p1_w0", flags(), 32'b000100);
        chk("t4_p1_rdata0", 32'(rdata), 32'(rom_word(8'h50)));
        step();
        chk("t4_p1_w1", flags(), 32'b000101);
        chk("t4_p1_rdata1", 32'(rdata), 32'(rom_word(8'h51)));
        step();
        chk("t4_idle", flags(), 32'h0);

        // 5: reset asserted after the 2nd word of an 8-word burst.
        req0 = 1'b1; addr0 = 8'h60; len0 = 4'd7;
        step();
        chk("t5_gnt0", flags(), 32'b100000);
        req0 = 1'b0;
        step();
        chk("t5_w0", flags(), 32'b001000);
        step();
        chk("t5_w1", flags(), 32'b001000);
        chk("t5_rdata1", 32'(rdata), 32'(rom_word(8'h61)));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_flags", flags(), 32'h0);
        chk("t5_async_rdata", 32'(rdata), 32'h0);
        chk("t5_async_rom_addr", 32'(rom_addr), 32'h0);
        chk("t5_async_state", 32'(fsm_state), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_after_flags", flags(), 32'h0);
        end
        req0 = 1'b1; addr0 = 8'h70; len0 = 4'd0;
        step();
        chk("t5_regnt", flags(), 32'b100000);
        req0 = 1'b0;
        step();
        chk("t5_revld", flags(), 32'b001010);
        chk("t5_rerdata", 32'(rdata), 32'(rom_word(8'h70)));

        // 6: 100 quiet cycles; nothing moves.
        for (int i = 0; i < 100; i++) begin
            step();
            chk("t6_flags", flags(), 32'h0);
            chk("t6_rom_addr", 32'(rom_addr), 32'h71);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rom_arbiter
